// File: rtl/axil_array_ctrl_if.sv
// AXI-Lite slave channels plus the single-port array interface of axil_array_ctrl.
// The slave modport is the controller side; master is the bus/array side.
interface axil_array_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 7
);
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rvalid;
    logic                s_axi_rready;
    logic                mem_en;
    logic                mem_we;
    logic [DATA_W/8-1:0] mem_be;
    logic [MEM_AW-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, mem_rdata,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, mem_rdata,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/axil_array_ctrl.sv
// AXI-Lite slave bridging to a one-cycle-latency word array, one transaction at a time.
// Write: bvalid 2 cycles after handshake; read: rvalid 3 cycles after; responses held until bready/rready.
module axil_array_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int MEM_AW = 7
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    axil_array_ctrl_if.slave  bus
);
    localparam int BE_W   = DATA_W / 8;
    localparam int WORD_W = ADDR_W - 2;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_MEM  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_MEM  = 3'd3;
    localparam logic [2:0] RD_CAP  = 3'd4;
    localparam logic [2:0] RD_RESP = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]        state;
    logic              last_grant;   // 1 = write was granted last
    logic              oor_q;
    logic              wr_req, rd_req, grant_wr, grant_rd, idle_ok;
    logic              wr_hs, rd_hs;
    logic [WORD_W-1:0] aw_word, ar_word;
    logic              aw_oor, ar_oor;

    logic              bvalid_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_en_q, mem_we_q;
    logic [BE_W-1:0]   mem_be_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Byte-offset address bits carry no meaning for word accesses.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0]};

    always_comb begin
        aw_word  = bus.s_axi_awaddr[ADDR_W-1:2];
        ar_word  = bus.s_axi_araddr[ADDR_W-1:2];
        aw_oor   = 32'(aw_word) >= 32'(DEPTH);
        ar_oor   = 32'(ar_word) >= 32'(DEPTH);
        wr_req   = bus.s_axi_awvalid && bus.s_axi_wvalid;
        rd_req   = bus.s_axi_arvalid;
        // Under contention the read wins unless it was granted last.
        grant_rd = rd_req && (!wr_req || last_grant);
        grant_wr = wr_req && !grant_rd;
        idle_ok  = (state == IDLE) && s_axi_aresetn;
        wr_hs    = idle_ok && grant_wr;
        rd_hs    = idle_ok && grant_rd;
    end

    assign bus.s_axi_awready = wr_hs;
    assign bus.s_axi_wready  = wr_hs;
    assign bus.s_axi_arready = rd_hs;
    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_bresp   = bresp_q;
    assign bus.s_axi_rvalid  = rvalid_q;
    assign bus.s_axi_rresp   = rresp_q;
    assign bus.s_axi_rdata   = rdata_q;
    assign bus.mem_en        = mem_en_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_be        = mem_be_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            oor_q       <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            rvalid_q    <= 1'b0;
            rresp_q     <= 2'b00;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // The array is strobed for exactly one cycle per in-range access.
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hs) begin
                        last_grant  <= 1'b1;
                        oor_q       <= aw_oor;
                        mem_en_q    <= !aw_oor;
                        mem_we_q    <= !aw_oor;
                        mem_be_q    <= bus.s_axi_wstrb;
                        mem_addr_q  <= MEM_AW'(aw_word);
                        mem_wdata_q <= bus.s_axi_wdata;
                        state       <= WR_MEM;
                    end else if (rd_hs) begin
                        last_grant  <= 1'b0;
                        oor_q       <= ar_oor;
                        mem_en_q    <= !ar_oor;
                        mem_addr_q  <= MEM_AW'(ar_word);
                        state       <= RD_MEM;
                    end
                end
                WR_MEM: begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= oor_q ? RESP_SLVERR : RESP_OKAY;
                    state    <= WR_RESP;
                end
                WR_RESP: begin
                    if (bus.s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RD_MEM: state <= RD_CAP;
                RD_CAP: begin
                    rdata_q  <= oor_q ? '0 : bus.mem_rdata;
                    rresp_q  <= oor_q ? RESP_SLVERR : RESP_OKAY;
                    rvalid_q <= 1'b1;
                    state    <= RD_RESP;
                end
                RD_RESP: begin
                    if (bus.s_axi_rready) begin
                        rvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_array_ctrl.sv
// Directed bench for axil_array_ctrl: vector table of single transactions plus
// contention, backpressure and mid-operation reset sequences against a behavioural array.
module tb_axil_array_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_init = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    axil_array_ctrl_if #(.ADDR_W(9), .DATA_W(32), .MEM_AW(7)) bus ();

    axil_array_ctrl #(.ADDR_W(9), .DATA_W(32), .DEPTH(64), .MEM_AW(7)) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .bus          (bus)
    );

    // Behavioural array: one-cycle read latency, byte-enabled writes.
    logic [31:0] mem [128];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    typedef struct {
        bit          is_wr;
        logic [8:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        bit          exp_en;
        logic [6:0]  exp_maddr;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d wr", idx);
        bus.s_axi_awaddr = v.addr;
        bus.s_axi_wdata = v.data;
        bus.s_axi_wstrb = v.strb;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid = 1'b1;
        bus.s_axi_bready = 1'b1;
        #1;
        check({p, " awready"}, bus.s_axi_awready, 1);
        check({p, " wready"}, bus.s_axi_wready, 1);
        step();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid = 1'b0;
        #1;
        check({p, " mem_en"}, bus.mem_en, v.exp_en);
        check({p, " mem_we"}, bus.mem_we, v.exp_en);
        if (v.exp_en) begin
            check({p, " mem_addr"}, bus.mem_addr, v.exp_maddr);
            check({p, " mem_be"}, bus.mem_be, v.strb);
            check({p, " mem_wdata"}, bus.mem_wdata, v.data);
        end
        check({p, " bvalid early"}, bus.s_axi_bvalid, 0);
        step();
        #1;
        check({p, " bvalid"}, bus.s_axi_bvalid, 1);
        check({p, " bresp"}, bus.s_axi_bresp, v.exp_resp);
        check({p, " mem_en off"}, bus.mem_en, 0);
        step();
        #1;
        check({p, " bvalid done"}, bus.s_axi_bvalid, 0);
    endtask

    task automatic do_read(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d rd", idx);
        bus.s_axi_araddr = v.addr;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_rready = 1'b1;
        #1;
        check({p, " arready"}, bus.s_axi_arready, 1);
        check({p, " awready"}, bus.s_axi_awready, 0);
        step();
        bus.s_axi_arvalid = 1'b0;
        #1;
        check({p, " mem_en"}, bus.mem_en, v.exp_en);
        check({p, " mem_we"}, bus.mem_we, 0);
        if (v.exp_en) check({p, " mem_addr"}, bus.mem_addr, v.exp_maddr);
        step();
        #1;
        check({p, " rvalid early"}, bus.s_axi_rvalid, 0);
        check({p, " mem_en off"}, bus.mem_en, 0);
        step();
        #1;
        check({p, " rvalid"}, bus.s_axi_rvalid, 1);
        check({p, " rdata"}, bus.s_axi_rdata, v.exp_rdata);
        check({p, " rresp"}, bus.s_axi_rresp, v.exp_resp);
        step();
        #1;
        check({p, " rvalid done"}, bus.s_axi_rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          ng;
        bit          g_kind [4];
        int          g_cyc [4];
        logic [31:0] cap;
        int          stray;
        vec_t        rv;

        vecs[0]  = '{1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 1'b1, 7'd4};
        vecs[1]  = '{1'b0, 9'h010, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 1'b1, 7'd4};
        vecs[2]  = '{1'b1, 9'h100, 32'h12345678, 4'hF, 32'h0,        2'b10, 1'b0, 7'd0};
        vecs[3]  = '{1'b0, 9'h1FC, 32'h0,        4'h0, 32'h0,        2'b10, 1'b0, 7'd0};
        vecs[4]  = '{1'b1, 9'h014, 32'h11223344, 4'h5, 32'h0,        2'b00, 1'b1, 7'd5};
        vecs[5]  = '{1'b0, 9'h014, 32'h0,        4'h0, 32'hA5220044, 2'b00, 1'b1, 7'd5};
        vecs[6]  = '{1'b0, 9'h0FC, 32'h0,        4'h0, 32'hA500003F, 2'b00, 1'b1, 7'd63};
        vecs[7]  = '{1'b0, 9'h000, 32'h0,        4'h0, 32'hA5000000, 2'b00, 1'b1, 7'd0};
        vecs[8]  = '{1'b1, 9'h0FE, 32'hCAFEF00D, 4'h8, 32'h0,        2'b00, 1'b1, 7'd63};
        vecs[9]  = '{1'b0, 9'h0FC, 32'h0,        4'h0, 32'hCA00003F, 2'b00, 1'b1, 7'd63};
        vecs[10] = '{1'b0, 9'h024, 32'h0,        4'h0, 32'h0BADCAFE, 2'b00, 1'b1, 7'd9};

        // Reset with every request asserted: nothing may be accepted.
        bus.s_axi_awaddr = 9'h024;
        bus.s_axi_wdata = 32'h0BADCAFE;
        bus.s_axi_wstrb = 4'hF;
        bus.s_axi_araddr = 9'h020;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid = 1'b1;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_bready = 1'b1;
        bus.s_axi_rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst arready", bus.s_axi_arready, 0);
        check("rst awready", bus.s_axi_awready, 0);
        check("rst wready", bus.s_axi_wready, 0);
        check("rst bvalid", bus.s_axi_bvalid, 0);
        check("rst rvalid", bus.s_axi_rvalid, 0);
        check("rst mem_en", bus.mem_en, 0);
        check("rst mem_we", bus.mem_we, 0);
        check("rst rdata", bus.s_axi_rdata, 0);
        check("rst mem_addr", bus.mem_addr, 0);
        check("rst bresp", bus.s_axi_bresp, 0);
        mem_init = 1'b0;
        rst_n = 1'b1;

        // Contention: read first, then alternate; grants at cycles 0, 4, 7, 11.
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (bus.s_axi_arready || bus.s_axi_awready) begin
                if (bus.s_axi_arready && bus.s_axi_awready) check("cont dual grant", 1, 0);
                g_kind[ng] = bus.s_axi_awready;
                g_cyc[ng] = c;
                ng++;
            end
            @(posedge clk);
            #1;
        end
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid = 1'b0;
        bus.s_axi_arvalid = 1'b0;
        check("cont grant count", ng, 4);
        if (ng == 4) begin
            check("cont g0 kind", g_kind[0], 0);
            check("cont g1 kind", g_kind[1], 1);
            check("cont g2 kind", g_kind[2], 0);
            check("cont g3 kind", g_kind[3], 1);
            check("cont g0 cyc", g_cyc[0], 0);
            check("cont g1 cyc", g_cyc[1], 4);
            check("cont g2 cyc", g_cyc[2], 7);
            check("cont g3 cyc", g_cyc[3], 11);
        end
        repeat (6) step();

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_wr) do_write(i, vecs[i]);
            else do_read(i, vecs[i]);
        end

        // Backpressure: response held for 5 cycles while a second read waits.
        bus.s_axi_araddr = 9'h010;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_rready = 1'b0;
        #1;
        check("bp arready", bus.s_axi_arready, 1);
        step();
        for (int c = 0; c < 10 && !bus.s_axi_rvalid; c++) step();
        #1;
        check("bp rvalid", bus.s_axi_rvalid, 1);
        cap = bus.s_axi_rdata;
        check("bp rdata", cap, 32'hDEADBEEF);
        for (int c = 0; c < 5; c++) begin
            step();
            #1;
            check($sformatf("bp hold%0d rvalid", c), bus.s_axi_rvalid, 1);
            check($sformatf("bp hold%0d rdata", c), bus.s_axi_rdata, cap);
            check($sformatf("bp hold%0d arready", c), bus.s_axi_arready, 0);
        end
        bus.s_axi_rready = 1'b1;
        step();
        #1;
        check("bp next arready", bus.s_axi_arready, 1);
        check("bp rvalid cleared", bus.s_axi_rvalid, 0);
        step();
        bus.s_axi_arvalid = 1'b0;
        repeat (6) step();

        // Reset while the read sits in RD_CAP.
        bus.s_axi_araddr = 9'h010;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_rready = 1'b0;
        #1;
        check("mid arready", bus.s_axi_arready, 1);
        step();
        bus.s_axi_arvalid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("mid rvalid", bus.s_axi_rvalid, 0);
        check("mid mem_en", bus.mem_en, 0);
        step();
        step();
        rst_n = 1'b1;
        bus.s_axi_rready = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            #1;
            if (bus.s_axi_rvalid || bus.s_axi_bvalid) stray++;
        end
        check("mid stray valid", stray, 0);

        // Reset while rvalid is up must clear it without waiting for a clock.
        bus.s_axi_araddr = 9'h010;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_rready = 1'b0;
        #1;
        step();
        bus.s_axi_arvalid = 1'b0;
        repeat (3) step();
        #1;
        check("async rvalid before", bus.s_axi_rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("async rvalid", bus.s_axi_rvalid, 0);
        check("async rdata", bus.s_axi_rdata, 0);
        step();
        rst_n = 1'b1;
        step();
        rv = vecs[1];
        do_read(99, rv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
